uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Parametrised UART transmitter with an input FIFO, valid/ready write side, configurable frame
//   (data bits, parity, stop bits) and CTS flow control. Successor to the single-byte TX: producers
//   push bursts without polling busy; frames go out back-to-back with no idle gap. Sits between
//   host/debug logic and the board TX pin.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per bit (100 MHz / 115200); legal >= 4
//   DATA_BITS     8    data bits per frame, legal 5..8, sent LSB first
//   PARITY        0    0 = none, 1 = odd, 2 = even
//   STOP_BITS     1    1 or 2 stop bits
//   FIFO_DEPTH    16   entries, power of two, >= 2
// PORTS
//   clk         in   1                         system clock
//   rst         in   1                         reset, synchronous, active-high
//   s_valid     in   1                         write request
//   s_data      in   DATA_BITS                 byte to queue
//   s_ready     out  1                         FIFO not full; write accepted when s_valid && s_ready
//   cts         in   1                         clear-to-send, active-high, asynchronous to clk
//   tx_line     out  1                         serial output, idle high
//   busy        out  1                         frame in progress or FIFO non-empty
//   fifo_count  out  $clog2(FIFO_DEPTH)+1      entries currently queued
// BEHAVIOUR
//   Reset: tx_line=1, busy=0, s_ready=1, fifo_count=0, state IDLE, all counters 0, FIFO emptied.
//     Reset mid-frame aborts the frame: tx_line high on the edge after rst asserted; queued data lost.
//   Write: s_ready = (fifo_count != FIFO_DEPTH), from registered count only (no combinational path
//     from pop). Accepted write increments count at that edge; write while full is ignored.
//   CTS: 2-flop synchroniser -> cts_s. Sampled only at frame start; deassert mid-frame completes frame.
//   FSM: IDLE, START, DATA, PARITY, STOP.
//     IDLE: tx_line=1. If count!=0 && cts_s: pop head into shifter, tx_line<=0, -> START.
//     START: hold 0 for CLKS_PER_BIT cycles -> DATA.
//     DATA: drive shifter[bit_idx], CLKS_PER_BIT each, bit_idx 0..DATA_BITS-1; then
//       -> PARITY if PARITY!=0 else -> STOP.
//     PARITY: odd: bit = ~^data; even: bit = ^data (over DATA_BITS bits only). -> STOP.
//     STOP: hold 1 for STOP_BITS*CLKS_PER_BIT cycles. On last cycle: if count!=0 && cts_s pop and
//       -> START (tx_line low next cycle, zero idle gap); else -> IDLE.
//   clk_cnt clears at every bit boundary; every bit is exactly CLKS_PER_BIT cycles.
//   Latency: write accepted at edge k into empty FIFO, idle FSM, cts_s high -> pop at edge k+1,
//     tx_line falls after edge k+1. Pop never reads the entry written in the same cycle.
//   Simultaneous write+pop: count unchanged; write+pop when full: write refused, count-1.
//   Pointers wrap modulo FIFO_DEPTH; count distinguishes full from empty.
//   busy = (state != IDLE) || (fifo_count != 0); registered outputs tx_line, busy.
// STRUCTURE
//   uart_pkg: parity_e enum (PAR_NONE/ODD/EVEN), tx state enum, default CLKS_PER_BIT constant.
//   Sub-module sync_fifo (WIDTH, DEPTH): single-clock FIFO, wr_en/rd_en, rd_data, count, full, empty.
//   Top holds CTS synchroniser, FSM, baud counter, bit index, shifter.
// TESTING (CLKS_PER_BIT=8 for sim speed; decode tx_line with a bit-centre sampler)
//   1. Defaults, write 0x55 once -> tx_line low 2 edges after accept; 10 bits x 8 clk, LSB first,
//      data 1,0,1,0,1,0,1,0, stop 1; busy drops after 80 cycles; count returns 0.
//   2. Burst 16 writes 0x00..0x0F with s_valid held -> s_ready low at count 16, 17th byte refused;
//      16 frames back-to-back with no idle cycles between stop and next start; order preserved.
//   3. DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x07 -> 7 data bits, parity 1, 16-cycle stop;
//      PARITY=1 same byte -> parity 0.
//   4. cts low, write 3 bytes -> tx_line stays 1, busy=1, count=3; raise cts -> first start bit
//      within 3 cycles; drop cts mid-frame 2 -> frame 2 completes, frame 3 held until cts high.
//   5. Assert rst mid-DATA with 4 queued -> next edge tx_line=1, busy=0, count=0, s_ready=1;
//      write after release transmits cleanly.
//   6. Write+pop same cycle at count 16 and at count 1 -> count goes 15 and stays 1 respectively.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a write while full is dropped even if a read happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from a FIFO; back-to-back frames, CTS checked only at frame start.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          s_ready,
  input  logic                          cts,
  output logic                          tx_line,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [1:0]       PAR_RAW   = PARITY[1:0];
  localparam parity_e          PAR_MODE  = parity_e'(PAR_RAW);

  tx_state_e             state, state_n;
  logic                  cts_m, cts_s;
  logic [CNT_W-1:0]      clk_cnt, clk_cnt_n;
  logic [IDX_W-1:0]      bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0]  shifter, shifter_n, fifo_rd_data;
  logic                  tx_n, pop, wr_acc, par_bit;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         count_n;

  assign s_ready = !fifo_full;
  assign wr_acc  = s_valid && s_ready;
  assign par_bit = (PAR_MODE == PAR_ODD) ? ~^shifter : ^shifter;
  assign count_n = fifo_count + CW'(wr_acc) - CW'(pop);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_valid),
    .wr_data (s_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt + CNT_W'(1);
    bit_idx_n = bit_idx;
    shifter_n = shifter;
    tx_n      = tx_line;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        clk_cnt_n = '0;
        tx_n      = 1'b1;
        if (!fifo_empty && cts_s) begin
          pop       = 1'b1;
          shifter_n = fifo_rd_data;
          tx_n      = 1'b0;
          state_n   = ST_START;
        end
      end
      ST_START: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          tx_n      = shifter[0];
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n = '0;
          if (bit_idx == IDX_LAST) begin
            if (PAR_MODE != PAR_NONE) begin
              tx_n    = par_bit;
              state_n = ST_PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = ST_STOP;
            end
          end else begin
            bit_idx_n = bit_idx + IDX_W'(1);
            tx_n      = shifter[bit_idx + IDX_W'(1)];
          end
        end
      end
      ST_PARITY: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n = '0;
          tx_n      = 1'b1;
          state_n   = ST_STOP;
        end
      end
      ST_STOP: begin
        // Chaining the next pop into the last stop cycle gives a zero-gap start bit.
        if (clk_cnt == STOP_LAST) begin
          clk_cnt_n = '0;
          if (!fifo_empty && cts_s) begin
            pop       = 1'b1;
            shifter_n = fifo_rd_data;
            tx_n      = 1'b0;
            state_n   = ST_START;
          end else begin
            tx_n    = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cts_m   <= 1'b0;
      cts_s   <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shifter <= '0;
      tx_line <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cts_m   <= cts;
      cts_s   <= cts_m;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      shifter <= shifter_n;
      tx_line <= tx_n;
      busy    <= (state_n != ST_IDLE) || (count_n != '0);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, 7E2 and 7O2 instances decoded with a bit-centre sampler.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       cts;
  logic [7:0] s_data;
  logic       s_valid0, s_valid_e, s_valid_o;
  logic       s_ready0, s_ready_e, s_ready_o;
  logic       tx0, tx_e, tx_o;
  logic       busy0, busy_e, busy_o;
  logic [4:0] cnt0, cnt_e, cnt_o;
  logic       rx, rx_busy;
  int         sel;
  int         checks = 0;
  int         errors = 0;
  int         n;
  logic       found;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid0), .s_data(s_data), .s_ready(s_ready0),
    .cts(cts), .tx_line(tx0), .busy(busy0), .fifo_count(cnt0)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_e (
    .clk(clk), .rst(rst), .s_valid(s_valid_e), .s_data(s_data[6:0]), .s_ready(s_ready_e),
    .cts(cts), .tx_line(tx_e), .busy(busy_e), .fifo_count(cnt_e)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_o (
    .clk(clk), .rst(rst), .s_valid(s_valid_o), .s_data(s_data[6:0]), .s_ready(s_ready_o),
    .cts(cts), .tx_line(tx_o), .busy(busy_o), .fifo_count(cnt_o)
  );

  always_comb begin
    case (sel)
      1:       begin rx = tx_e; rx_busy = busy_e; end
      2:       begin rx = tx_o; rx_busy = busy_o; end
      default: begin rx = tx0;  rx_busy = busy0;  end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fall(input int limit, output int waited, output logic seen);
    waited = 0;
    while (rx !== 1'b0 && waited < limit) begin
      tick();
      waited++;
    end
    seen = (rx === 1'b0);
  endtask

  // Entered on the first sample where the start bit is visible.
  task automatic get_frame(input string pfx, input logic [7:0] exp, input int nbits,
                           input int npar, input logic exp_par, input int nstop);
    logic [7:0] d;
    d = '0;
    repeat (4) tick();
    check({pfx, "_start"}, rx, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      repeat (8) tick();
      d[i] = rx;
    end
    check({pfx, "_data"}, d, exp);
    if (npar != 0) begin
      repeat (8) tick();
      check({pfx, "_par"}, rx, exp_par);
    end
    for (int s = 0; s < nstop; s++) begin
      repeat (8) tick();
      check({pfx, "_stop"}, rx, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cts = 1'b1; s_data = '0; sel = 0;
    s_valid0 = 1'b0; s_valid_e = 1'b0; s_valid_o = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    check("rst_tx", tx0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_ready", s_ready0, 1'b1);
    check("rst_count", cnt0, 0);

    // 1: single 0x55 frame, 8N1
    s_data = 8'h55; s_valid0 = 1'b1;
    tick();
    s_valid0 = 1'b0;
    check("t1_count", cnt0, 1);
    check("t1_idle", tx0, 1'b1);
    tick();
    check("t1_fall", tx0, 1'b0);
    get_frame("t1", 8'h55, 8, 0, 1'b0, 1);
    repeat (3) tick();
    check("t1_busy_hi", busy0, 1'b1);
    tick();
    check("t1_busy_lo", busy0, 1'b0);
    check("t1_count0", cnt0, 0);

    // 2: fill to 16 with CTS low, 17th refused, then write+pop while full
    cts = 1'b0;
    repeat (3) tick();
    for (int i = 0; i <= 16; i++) begin
      s_data = 8'(i); s_valid0 = 1'b1;
      check("t2_ready", s_ready0, (i < 16));
      tick();
    end
    check("t2_full", cnt0, 16);
    check("t2_ready_lo", s_ready0, 1'b0);
    cts = 1'b1;
    wait_fall(10, n, found);
    check("t2_found", found, 1'b1);
    check("t6_full_pop", cnt0, 15);
    s_valid0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        wait_fall(20, n, found);
        check("t2_gap", n, 4);
      end
      get_frame("t2", 8'(i), 8, 0, 1'b0, 1);
    end
    wait_fall(40, n, found);
    check("t2_no17", found, 1'b0);
    check("t2_count0", cnt0, 0);
    check("t2_busy0", busy0, 1'b0);

    // 3: 7E2 then 7O2 with 0x07
    for (int k = 1; k <= 2; k++) begin
      sel = k;
      s_data = 8'h07;
      if (k == 1) s_valid_e = 1'b1; else s_valid_o = 1'b1;
      tick();
      s_valid_e = 1'b0; s_valid_o = 1'b0;
      tick();
      check("t3_fall", rx, 1'b0);
      get_frame((k == 1) ? "t3e" : "t3o", 8'h07, 7, 1, (k == 1), 2);
      repeat (3) tick();
      check("t3_busy_hi", rx_busy, 1'b1);
      tick();
      check("t3_busy_lo", rx_busy, 1'b0);
    end
    sel = 0;

    // 4: CTS flow control
    cts = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      s_data = 8'hA1 + 8'(i * 17); s_valid0 = 1'b1;
      tick();
    end
    s_valid0 = 1'b0;
    repeat (10) tick();
    check("t4_hold_tx", tx0, 1'b1);
    check("t4_busy", busy0, 1'b1);
    check("t4_count", cnt0, 3);
    cts = 1'b1;
    wait_fall(3, n, found);
    check("t4_cts_lat", found, 1'b1);
    get_frame("t4a", 8'hA1, 8, 0, 1'b0, 1);
    wait_fall(10, n, found);
    check("t4_gap", n, 4);
    cts = 1'b0;
    get_frame("t4b", 8'hB2, 8, 0, 1'b0, 1);
    wait_fall(40, n, found);
    check("t4_held", found, 1'b0);
    check("t4_count1", cnt0, 1);
    check("t4_busy1", busy0, 1'b1);
    cts = 1'b1;
    wait_fall(5, n, found);
    check("t4_resume", found, 1'b1);
    get_frame("t4c", 8'hC3, 8, 0, 1'b0, 1);
    repeat (4) tick();

    // 6: write and pop in the same cycle at count 1
    cts = 1'b0;
    repeat (3) tick();
    s_data = 8'h11; s_valid0 = 1'b1;
    tick();
    s_valid0 = 1'b0;
    check("t6_count1", cnt0, 1);
    cts = 1'b1;
    repeat (2) tick();
    s_data = 8'h22; s_valid0 = 1'b1;
    tick();
    s_valid0 = 1'b0;
    check("t6_fall", tx0, 1'b0);
    check("t6_stay1", cnt0, 1);
    get_frame("t6a", 8'h11, 8, 0, 1'b0, 1);
    wait_fall(10, n, found);
    check("t6_gap", n, 4);
    get_frame("t6b", 8'h22, 8, 0, 1'b0, 1);
    repeat (4) tick();
    check("t6_busy0", busy0, 1'b0);

    // 5: reset mid-DATA with 4 queued
    for (int i = 0; i < 5; i++) begin
      s_data = 8'h81 + 8'(i); s_valid0 = 1'b1;
      tick();
    end
    s_valid0 = 1'b0;
    check("t5_count4", cnt0, 4);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check("t5_tx", tx0, 1'b1);
    check("t5_busy", busy0, 1'b0);
    check("t5_count", cnt0, 0);
    check("t5_ready", s_ready0, 1'b1);
    rst = 1'b0;
    repeat (2) tick();
    s_data = 8'h3C; s_valid0 = 1'b1;
    tick();
    s_valid0 = 1'b0;
    wait_fall(10, n, found);
    check("t5_found", found, 1'b1);
    get_frame("t5", 8'h3C, 8, 0, 1'b0, 1);
    repeat (4) tick();
    check("t5_busy0", busy0, 1'b0);
    check("t5_count0", cnt0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
